// File: rtl/mult_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM state encodings.
package mult_pkg;
  typedef logic [1:0] mstate_t;
  localparam mstate_t IDLE = 2'd0;
  localparam mstate_t RUN  = 2'd1;
  localparam mstate_t DONE = 2'd2;
endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, fixed WIDTH-iteration latency, signed/unsigned operands.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  mstate_t            state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
  logic [WIDTH-1:0]   mplier;
  logic               smode;
  logic               last;
  logic               accept;

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign last   = (cnt == CNT_W'(WIDTH-1));
  assign accept = start && (state == IDLE || state == DONE);

  // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so that
  // partial product is subtracted; the sign-extended multiplicand handles B.
  always_comb begin
    acc_nxt = acc;
    if (mplier[0])
      acc_nxt = (smode && last) ? acc - mcand : acc + mcand;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      smode   <= 1'b0;
      product <= '0;
    end else if (accept) begin
      state  <= RUN;
      cnt    <= '0;
      acc    <= '0;
      mplier <= multiplier;
      mcand  <= {{WIDTH{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
      smode  <= signed_mode;
    end else if (state == RUN) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        state   <= DONE;
        product <= acc_nxt;
      end
    end else begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, sm4, start8, sm8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  product4;
  logic [15:0] product8;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic [63:0] exp;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .multiplier(a4), .multiplicand(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .multiplier(a8), .multiplicand(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input bit s);
    longint ax, bx, p;
    ax = longint'(a);
    bx = longint'(b);
    if (s && a[w-1]) ax = ax - (longint'(1) << w);
    if (s && b[w-1]) bx = bx - (longint'(1) << w);
    p = ax * bx;
    return 64'(p & ((longint'(1) << (2*w)) - 1));
  endfunction

  // Result monitors: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) chk("done4_unexpected", 1, 0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("prod4", 64'(product4), e.exp);
        chk("lat4", 64'(cyc - e.cyc + 1), 64'd5);
      end
    end
    if (done8) begin
      if (q8.size() == 0) chk("done8_unexpected", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("prod8", 64'(product8), e.exp);
        chk("lat8", 64'(cyc - e.cyc + 1), 64'd9);
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accept edge.
  task automatic go4(input logic [31:0] a, input logic [31:0] b, input bit s, input bit push);
    exp_t e;
    a4 = a[3:0]; b4 = b[3:0]; sm4 = s; start4 = 1'b1;
    if (push) begin
      e.exp = model(4, 32'(a[3:0]), 32'(b[3:0]), s);
      e.cyc = cyc + 1;
      q4.push_back(e);
    end
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic go8(input logic [31:0] a, input logic [31:0] b, input bit s);
    exp_t e;
    a8 = a[7:0]; b8 = b[7:0]; sm8 = s; start8 = 1'b1;
    e.exp = model(8, 32'(a[7:0]), 32'(b[7:0]), s);
    e.cyc = cyc + 1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done4();
    for (int i = 0; i < 20 && !done4; i++) @(negedge clk);
    if (!done4) chk("timeout4", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 30 && !done8; i++) @(negedge clk);
    if (!done8) chk("timeout8", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_prod4", product4, 0);
    chk("rst_prod8", product8, 0);
    rst = 1'b0;
    @(negedge clk);

    // 13x15 unsigned: busy for 4 cycles, done pulse, then a held result
    go4(13, 15, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", busy4, 1);
      chk("prod_hold_busy", product4, 0);
      @(negedge clk);
    end
    chk("done_pulse", done4, 1);
    chk("busy_in_done", busy4, 0);
    @(negedge clk);
    chk("done_single", done4, 0);
    for (int i = 0; i < 10; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
      chk("prod_hold_idle", product4, 8'hC3);
      chk("idle_busy", busy4, 0);
      @(negedge clk);
    end

    // Directed signed/unsigned corner cases, then random ones
    begin
      logic [3:0] ta[7] = '{13, 8, 13, 8, 8, 0, 1};
      logic [3:0] tb[7] = '{5, 8, 5, 8, 0, 15, 15};
      bit         ts[7] = '{1, 1, 0, 0, 0, 0, 0};
      for (int i = 0; i < 7; i++) begin
        go4(32'(ta[i]), 32'(tb[i]), ts[i], 1);
        wait_done4();
      end
    end
    for (int i = 0; i < 8; i++) begin
      go4($urandom, $urandom, 1'($urandom), 1);
      wait_done4();
    end

    // Noise on start/operands during RUN, then back-to-back accept in DONE
    go4(13, 15, 0, 1);
    for (int i = 0; i < 4; i++) begin
      start4 = (i % 2 == 0);
      a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
      @(negedge clk);
    end
    start4 = 1'b0;
    chk("b2b_done", done4, 1);
    go4(14, 9, 0, 1);
    chk("b2b_nogap", busy4, 1);
    chk("b2b_prod_hold", product4, 8'hC3);
    wait_done4();
    chk("b2b_result", product4, 8'd126);

    // Reset two edges into a RUN aborts it asynchronously
    go4(13, 15, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_prod", product4, 0);
    @(negedge clk);
    rst = 1'b0;
    go4(4, 13, 0, 1);
    wait_done4();

    // WIDTH=8
    go8(255, 255, 0);
    wait_done8();
    chk("w8_max", product8, 16'hFE01);
    go8(8'h80, 8'h7F, 1);
    wait_done8();
    chk("w8_signed", product8, 16'hC080);
    go8(8'h80, 8'h80, 1);
    wait_done8();
    for (int i = 0; i < 6; i++) begin
      go8($urandom, $urandom, 1'($urandom));
      wait_done8();
    end

    repeat (3) @(negedge clk);
    chk("q4_drained", 64'(q4.size()), 0);
    chk("q8_drained", 64'(q8.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
